// File: rtl/matrix_loader.sv
// matrix_loader: byte-stream front end for the matrix coprocessor core.
// Takes a header (size, opcode), matrix A, then matrix B or a scalar.
// Elements are packed into zero-padded 5x5 row-major 200-bit words. Memory
// words 0 (header), 1 (A) and 2 (B) are written, core_start is pulsed, and
// busy is held until the core reports completion with core_ready.
//
// Build option: define LOADER_TIMEOUT_EN to abort the wait for core_ready
// after TIMEOUT_CYCLES cycles, setting err. The default build waits forever.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// HDR_SIZE | idle, waiting for the size byte (in_ready=1)
// HDR_OP   | waiting for the opcode byte
// LOAD_A   | receiving N*N elements of A, row-major
// LOAD_B   | receiving N*N elements of B, or one scalar (opcode 3)
// WR_HDR   | writing the header to memory word 0
// WR_A     | writing A to memory word 1
// WR_B     | writing B to memory word 2
// START    | one-cycle core_start pulse
// WAIT     | waiting for core_ready (or a timeout when enabled)

module matrix_loader #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk_button,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         mem_sel,
    output logic [1:0]   mem_addr,
    output logic [199:0] mem_data,
    output logic         mem_wren,
    output logic         core_start,
    input  logic         core_ready,
    output logic         busy,
    output logic         err
);

    typedef enum logic [3:0] {
        HDR_SIZE, HDR_OP, LOAD_A, LOAD_B, WR_HDR, WR_A, WR_B, START, WAIT
    } state_t;

    state_t         state;
    logic [1:0]     msize;
    logic [2:0]     opcode;
    logic [199:0]   a_buf;
    logic [199:0]   b_buf;
    logic [2:0]     row;
    logic [2:0]     col;

    logic [2:0]     n_last;
    logic [7:0]     elem_hi;
    logic           last_elem;
    logic           xfer;
    logic           load_done;
    logic [199:0]   hdr_word;

    // The wait window is measured from the core_start cycle, so the START
    // cycle counts as the first cycle and at least two cycles are needed.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("matrix_loader: TIMEOUT_CYCLES must be at least 2");
    end

`ifdef LOADER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 2);
    logic [CW-1:0]  wait_cnt;
`endif

    // Element placement, handshake and end-of-stream detection.
    always_comb begin
        n_last    = {1'b0, msize} + 3'd1;
        elem_hi   = 8'd199 - 8'd40 * {5'd0, row} - 8'd8 * {5'd0, col};
        last_elem = (row == n_last) && (col == n_last);
        xfer      = in_valid && in_ready;
        hdr_word  = {184'b0, 5'b0, opcode, 6'b0, msize};
        load_done = 1'b0;
        if (xfer && state == LOAD_A && last_elem && opcode >= 3'd4) begin
            load_done = 1'b1;
        end
        if (xfer && state == LOAD_B && (opcode == 3'd3 || last_elem)) begin
            load_done = 1'b1;
        end
    end

    // Command sequencer with registered outputs.
    always_ff @(posedge clk_button or posedge rst) begin
        if (rst) begin
            state      <= HDR_SIZE;
            msize      <= '0;
            opcode     <= '0;
            a_buf      <= '0;
            b_buf      <= '0;
            row        <= '0;
            col        <= '0;
            in_ready   <= 1'b0;
            mem_sel    <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_wren   <= 1'b0;
            core_start <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            core_start <= 1'b0;
            case (state)
                HDR_SIZE: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        msize <= in_data[1:0];
                        a_buf <= '0;
                        b_buf <= '0;
                        row   <= '0;
                        col   <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= HDR_OP;
                    end
                end
                HDR_OP: begin
                    if (xfer) begin
                        opcode <= in_data[2:0];
                        if (in_data[2:0] == 3'd7) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= HDR_SIZE;
                        end else begin
                            state <= LOAD_A;
                        end
                    end
                end
                LOAD_A: begin
                    if (xfer) begin
                        a_buf[elem_hi -: 8] <= in_data;
                        if (last_elem) begin
                            row   <= '0;
                            col   <= '0;
                            state <= LOAD_B;
                        end else if (col == n_last) begin
                            col <= '0;
                            row <= row + 3'd1;
                        end else begin
                            col <= col + 3'd1;
                        end
                    end
                end
                LOAD_B: begin
                    if (xfer) begin
                        if (opcode == 3'd3) begin
                            b_buf[7:0] <= in_data;
                        end else begin
                            b_buf[elem_hi -: 8] <= in_data;
                            if (col == n_last) begin
                                col <= '0;
                                row <= row + 3'd1;
                            end else begin
                                col <= col + 3'd1;
                            end
                        end
                    end
                end
                WR_HDR: begin
                    mem_addr <= 2'd1;
                    mem_data <= a_buf;
                    state    <= WR_A;
                end
                WR_A: begin
                    mem_addr <= 2'd2;
                    mem_data <= b_buf;
                    state    <= WR_B;
                end
                WR_B: begin
                    mem_sel    <= 1'b0;
                    mem_wren   <= 1'b0;
                    mem_addr   <= '0;
                    core_start <= 1'b1;
                    state      <= START;
                end
                START: begin
`ifdef LOADER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (core_ready) begin
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= HDR_SIZE;
                    end
`ifdef LOADER_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= HDR_SIZE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: state <= HDR_SIZE;
            endcase

            // Final element received: present the header write next cycle.
            // Placed after the case so it overrides the LOAD_B transition.
            if (load_done) begin
                in_ready <= 1'b0;
                mem_sel  <= 1'b1;
                mem_wren <= 1'b1;
                mem_addr <= 2'd0;
                mem_data <= hdr_word;
                state    <= WR_HDR;
            end
        end
    end

endmodule

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
- Upstream feeder for the matrix coprocessor core.
- Accepts a byte stream from the HPS bridge over a valid/ready handshake: a header (size, opcode), then matrix A, then matrix B or a scalar.
- Packs the elements into the zero-padded 5x5 row-major 200-bit format, writes memory words 0/1/2, pulses the core's start and holds busy until the core reports ready.

Parameters:
- TIMEOUT_CYCLES, 255, cycles to wait for core_ready before aborting (used only with LOADER_TIMEOUT_EN).

Ports:
- clk_button  input  1  clock (same clock as the core).
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  8  stream byte (header field or signed 8-bit element).
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_sel  output  1  1 = loader owns the memory port (external mux).
- mem_addr  output  2  memory word address.
- mem_data  output  200  memory write data.
- mem_wren  output  1  memory write enable.
- core_start  output  1  one-cycle start pulse to the core.
- core_ready  input  1  core result-written pulse.
- busy  output  1  command in progress (from the first accepted header byte until return to HDR_SIZE).
- err  output  1  sticky error flag.

Behaviour:
- Reset values:
  - in_ready=0, mem_sel=0, mem_addr=0, mem_data=0, mem_wren=0, core_start=0, busy=0, err=0.
  - A/B buffers cleared, state HDR_SIZE.
  - in_ready goes to 1 on the first clock after reset release.
- Transfer rule:
  - A byte is consumed at a posedge when in_valid && in_ready.
  - in_ready=1 only in HDR_SIZE, HDR_OP, LOAD_A, LOAD_B.
- HDR_SIZE:
  - On transfer: msize=in_data[1:0]; N=msize+2; A/B buffers and row/col counters cleared; err cleared; busy=1; go to HDR_OP.
- HDR_OP:
  - opcode=in_data[2:0].
  - Opcode 7: err=1, busy=0, go back to HDR_SIZE.
  - Otherwise go to LOAD_A.
- LOAD_A:
  - N*N transfers, row-major.
  - Element (r,c) goes to A[199-40r-8c -: 8].
  - c increments and wraps at N-1, then r increments.
  - After element (N-1,N-1), go to next state by opcode:
    - opcode 0,1,2 -> LOAD_B.
    - opcode 3 -> LOAD_B (scalar mode).
    - opcode 4,5,6 -> WR_HDR, with B left all-zero.
- LOAD_B:
  - Opcode 0/1/2: same placement as A, N*N transfers.
  - Opcode 3: exactly one transfer, placed at B[7:0], rest zero.
  - Then go to WR_HDR.
- Write phase (one cycle each, mem_sel=1, mem_wren=1, registered outputs):
  - WR_HDR: addr 0, data = {184'b0, 5'b0, opcode, 6'b0, msize}.
  - WR_A: addr 1, data = A.
  - WR_B: addr 2, data = B.
- START:
  - mem_sel=0, mem_wren=0, mem_addr=0, core_start=1 for exactly one cycle.
  - Go to WAIT.
- WAIT:
  - core_start=0.
  - On core_ready=1: busy=0, go to HDR_SIZE.
  - in_valid is ignored (in_ready=0).
- Latency:
  - The last stream byte is accepted at edge k.
  - WR_HDR is active in cycle k+1, WR_B in k+3, core_start in k+4.
- Padding: positions with r>=N or c>=N are always 0 in A and B.
- A core_ready pulse outside WAIT is ignored.
- Reset mid-operation (any state): immediate return to reset values; partial buffers discarded; no further memory writes.
- A new header can only be accepted in HDR_SIZE, so a second command waits until the first completes.

Optional Feature:
- LOADER_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - If core_ready has not arrived after TIMEOUT_CYCLES cycles: err=1, busy=0, go to HDR_SIZE.
  - The counter clears on entering WAIT.
- LOADER_TIMEOUT_EN undefined: WAIT holds indefinitely until core_ready or rst; no counter logic.

Test Plan:
- 2x2 add: stream 00,00, A=01,02,03,04, B=05,06,07,08 ->
  - word1 = 0x0102 at [199:184] and 0x0304 at [159:144], all else 0.
  - word0[15:0] = 0x0000.
  - Three writes to addr 0,1,2 on consecutive cycles, then core_start 1 cycle; busy falls after a core_ready pulse.
- 5x5 transpose: stream 03,05, then 25 bytes 00..18 ->
  - word1 = 0x00..18 packed MSB-first.
  - word2 = 0, word0[15:0] = 0x0503.
  - No LOAD_B transfers accepted; in_ready=0 after the 27th byte.
- 3x3 mult-by-int: stream 01,03, nine bytes, then scalar FE ->
  - word2 = 0x...00FE (only [7:0] nonzero).
  - in_ready drops after the scalar.
- Bad opcode: stream 02,07 -> err=1, busy=0, no mem_wren, in_ready=1. A following valid header clears err.
- Backpressure/reset: toggle in_valid randomly during LOAD_A, then assert rst mid-LOAD_B ->
  - All outputs reach reset values asynchronously; mem_wren never asserted.
  - A fresh command afterwards produces a clean word1 with no leftover bytes.
- LOADER_TIMEOUT_EN with TIMEOUT_CYCLES=10 and core_ready held 0 -> err=1 and busy=0 exactly 10 cycles after the core_start cycle.
